// File: rtl/trap_unit_pkg.sv
// Shared constants for the machine-mode trap sequencer: CSR addresses, cause codes,
// mstatus bit positions and the FSM state encoding.
package trap_unit_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
  localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
  localparam logic [31:0] CAUSE_MEI        = 32'h8000_000B;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MEIE     = 11;
  localparam int MIP_MEIP     = 11;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_VECTOR = 1'b1
  } state_e;

  // One trap request as seen by the CSR file on the detect cycle.
  typedef struct packed {
    logic        take;
    logic [31:0] cause;
    logic [31:0] tval;
  } trap_req_t;

endpackage

// File: rtl/trap_unit_if.sv
// Decoder-to-trap-unit bundle: exception flags, CSR access and PC redirect outputs.
// master = core/decoder side, slave = trap_unit.
interface trap_unit_if;
  logic [31:0] I_pc;
  logic [31:0] I_inst;
  logic        I_ecall;
  logic        I_ebreak;
  logic        I_illegalinst;
  logic        I_mret;
  logic        I_csrwen;
  logic [11:0] I_csraddr;
  logic [31:0] I_csrwdata;
  logic        I_extirq;
  logic [31:0] O_csrrdata;
  logic        O_stall;
  logic        O_redirect;
  logic [31:0] O_redirectpc;

  modport master (
    output I_pc, I_inst, I_ecall, I_ebreak, I_illegalinst, I_mret,
           I_csrwen, I_csraddr, I_csrwdata, I_extirq,
    input  O_csrrdata, O_stall, O_redirect, O_redirectpc
  );

  modport slave (
    input  I_pc, I_inst, I_ecall, I_ebreak, I_illegalinst, I_mret,
           I_csrwen, I_csraddr, I_csrwdata, I_extirq,
    output O_csrrdata, O_stall, O_redirect, O_redirectpc
  );
endinterface

// File: rtl/trap_csrfile.sv
// Machine CSR storage, combinational read mux and write decode for trap_unit.
// Interrupt CSR bits (mie.MEIE, mip.MEIP) exist only when TRAP_EXTIRQ_EN is defined.
module trap_csrfile
  import trap_unit_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] addr,
  input  logic        wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  trap_req_t   trap,
  input  logic [31:0] trap_pc,
  input  logic        mret,
  input  logic        extirq,
  output logic [31:0] mtvec,
  output logic [31:0] mepc,
  output logic        irq_pending
);

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [29:0] mtvec_q;
  logic [29:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic        meie;
  logic        meip;

  // Exception PCs are word aligned, so the low bits of the trap PC are dropped.
  logic unused_pc_bits;
  assign unused_pc_bits = ^trap_pc[1:0];

  assign mtvec = {mtvec_q, 2'b00};
  assign mepc  = {mepc_q, 2'b00};

`ifdef TRAP_EXTIRQ_EN
  logic meie_q;
  assign meie = meie_q;
  assign meip = extirq;

  always_ff @(posedge clk) begin
    if (rst) begin
      meie_q <= 1'b0;
    end else if (wen && addr == CSR_MIE && !trap.take && !mret) begin
      meie_q <= wdata[MIE_MEIE];
    end
  end
`else
  logic unused_extirq;
  assign unused_extirq = extirq;
  assign meie = 1'b0;
  assign meip = 1'b0;
`endif

  assign irq_pending = mstatus_mie & meie & meip;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; trap entry, mret and CSR writes are mutually exclusive here.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mtvec_q      <= RESET_MTVEC[31:2];
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
    end else if (trap.take) begin
      mepc_q       <= trap_pc[31:2];
      mcause_q     <= trap.cause;
      mtval_q      <= trap.tval;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (wen) begin
      case (addr)
        CSR_MSTATUS: begin
          mstatus_mie  <= wdata[MSTATUS_MIE];
          mstatus_mpie <= wdata[MSTATUS_MPIE];
        end
        CSR_MTVEC:  mtvec_q  <= wdata[31:2];
        CSR_MEPC:   mepc_q   <= wdata[31:2];
        CSR_MCAUSE: mcause_q <= wdata;
        CSR_MTVAL:  mtval_q  <= wdata;
        default: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first, so no latch is inferred.
  always_comb begin
    rdata = '0;
    case (addr)
      CSR_MSTATUS: begin
        rdata[MSTATUS_MIE]  = mstatus_mie;
        rdata[MSTATUS_MPIE] = mstatus_mpie;
      end
      CSR_MIE:    rdata[MIE_MEIE] = meie;
      CSR_MTVEC:  rdata = mtvec;
      CSR_MEPC:   rdata = mepc;
      CSR_MCAUSE: rdata = mcause_q;
      CSR_MTVAL:  rdata = mtval_q;
      CSR_MIP:    rdata[MIP_MEIP] = meip;
      default:    rdata = '0;
    endcase
  end

endmodule

// File: rtl/trap_unit.sv
// Machine-mode trap sequencer: prioritises exceptions/interrupt/MRET/CSR write and
// drives stall and PC redirect. Optional interrupt path: define TRAP_EXTIRQ_EN.
module trap_unit
  import trap_unit_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
  input logic        I_clk,
  input logic        I_rst,
  trap_unit_if.slave bus
);

  state_e      state_q;
  state_e      state_d;
  trap_req_t   trap;
  logic        mret_take;
  logic        csr_wen;
  logic        irq_pending;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  trap_csrfile #(
    .RESET_MTVEC(RESET_MTVEC)
  ) u_csrfile (
    .clk        (I_clk),
    .rst        (I_rst),
    .addr       (bus.I_csraddr),
    .wen        (csr_wen),
    .wdata      (bus.I_csrwdata),
    .rdata      (bus.O_csrrdata),
    .trap       (trap),
    .trap_pc    (bus.I_pc),
    .mret       (mret_take),
    .extirq     (bus.I_extirq),
    .mtvec      (mtvec),
    .mepc       (mepc),
    .irq_pending(irq_pending)
  );

  always_ff @(posedge I_clk) begin
    if (I_rst) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    trap        = '0;
    mret_take   = 1'b0;
    csr_wen     = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    case (state_q)
      ST_RUN: begin
        if (bus.I_illegalinst) begin
          trap = '{take: 1'b1, cause: CAUSE_ILLEGAL, tval: bus.I_inst};
        end else if (bus.I_ebreak) begin
          trap = '{take: 1'b1, cause: CAUSE_BREAKPOINT, tval: bus.I_pc};
        end else if (bus.I_ecall) begin
          trap = '{take: 1'b1, cause: CAUSE_ECALL_M, tval: 32'h0};
        end else if (irq_pending) begin
          trap = '{take: 1'b1, cause: CAUSE_MEI, tval: 32'h0};
        end else if (bus.I_mret) begin
          mret_take   = 1'b1;
          redirect    = 1'b1;
          redirect_pc = mepc;
        end else begin
          csr_wen = bus.I_csrwen;
        end
        if (trap.take) begin
          stall   = 1'b1;
          state_d = ST_VECTOR;
        end
      end
      // Faulting instruction is still held in execute; keep it stalled while fetching the handler.
      ST_VECTOR: begin
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = mtvec;
        state_d     = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign bus.O_stall      = stall;
  assign bus.O_redirect   = redirect;
  assign bus.O_redirectpc = redirect_pc;

endmodule

// File: tb/tb_trap_unit.sv
// Self-checking bench for trap_unit: directed scenarios followed by random stimulus
// compared against a behavioural model of the machine trap rules.
module tb_trap_unit;

  localparam logic [31:0] RESET_MTVEC = 32'h0000_0100;
`ifdef TRAP_EXTIRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trap_unit_if bus ();

  trap_unit #(
    .RESET_MTVEC(RESET_MTVEC)
  ) dut (
    .I_clk(clk),
    .I_rst(rst),
    .bus  (bus.slave)
  );

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ecall;
    logic        ebreak;
    logic        illegal;
    logic        mret;
    logic        csrwen;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        extirq;
  } stim_t;

  int tests = 0;
  int fails = 0;

  // Architectural model state
  bit          m_vec;
  bit          m_mie, m_mpie, m_meie;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;

  logic        obs_stall, obs_redir;
  logic [31:0] obs_rpc, obs_rdata;

  function automatic void model_reset();
    m_vec    = 1'b0;
    m_mie    = 1'b0;
    m_mpie   = 1'b0;
    m_meie   = 1'b0;
    m_mtvec  = RESET_MTVEC & 32'hFFFF_FFFC;
    m_mepc   = 32'h0;
    m_mcause = 32'h0;
    m_mtval  = 32'h0;
  endfunction

  function automatic logic [31:0] model_read(logic [11:0] a, logic irq_line);
    case (a)
      12'h300: return (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h304: return 32'(m_meie) << 11;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return 32'(IRQ_EN && irq_line) << 11;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic stim_t idle(logic [31:0] pc);
    stim_t s;
    s.rst = 1'b0; s.pc = pc; s.inst = 32'h0000_0013;
    s.ecall = 1'b0; s.ebreak = 1'b0; s.illegal = 1'b0; s.mret = 1'b0;
    s.csrwen = 1'b0; s.addr = 12'h7C0; s.wdata = 32'h0; s.extirq = 1'b0;
    return s;
  endfunction

  function automatic stim_t rd(logic [11:0] a);
    stim_t s = idle(32'h1000);
    s.addr = a;
    return s;
  endfunction

  function automatic stim_t wr(logic [11:0] a, logic [31:0] d);
    stim_t s = idle(32'h1004);
    s.addr = a; s.wdata = d; s.csrwen = 1'b1;
    return s;
  endfunction

  // Drives one cycle, checks all outputs against the model, then advances the model.
  task automatic cycle(input stim_t s);
    logic irq, trap_evt, e_stall, e_redir;
    logic [31:0] e_rpc, e_rdata;
    rst = s.rst;
    bus.I_pc = s.pc; bus.I_inst = s.inst;
    bus.I_ecall = s.ecall; bus.I_ebreak = s.ebreak; bus.I_illegalinst = s.illegal;
    bus.I_mret = s.mret; bus.I_csrwen = s.csrwen; bus.I_csraddr = s.addr;
    bus.I_csrwdata = s.wdata; bus.I_extirq = s.extirq;

    irq      = IRQ_EN && m_mie && m_meie && s.extirq;
    trap_evt = s.illegal || s.ebreak || s.ecall || irq;
    if (m_vec)         begin e_stall = 1; e_redir = 1; e_rpc = m_mtvec; end
    else if (trap_evt) begin e_stall = 1; e_redir = 0; e_rpc = 0; end
    else if (s.mret)   begin e_stall = 0; e_redir = 1; e_rpc = m_mepc; end
    else               begin e_stall = 0; e_redir = 0; e_rpc = 0; end
    e_rdata = model_read(s.addr, s.extirq);

    @(negedge clk);
    obs_stall = bus.O_stall; obs_redir = bus.O_redirect;
    obs_rpc   = bus.O_redirectpc; obs_rdata = bus.O_csrrdata;
    check("stall", 32'(obs_stall), 32'(e_stall));
    check("redirect", 32'(obs_redir), 32'(e_redir));
    check("redirectpc", obs_rpc, e_rpc);
    check("csrrdata", obs_rdata, e_rdata);

    @(posedge clk);
    if (s.rst) model_reset();
    else if (m_vec) m_vec = 1'b0;
    else if (trap_evt) begin
      m_mepc = s.pc & 32'hFFFF_FFFC;
      if (s.illegal)     begin m_mcause = 32'd2;  m_mtval = s.inst; end
      else if (s.ebreak) begin m_mcause = 32'd3;  m_mtval = s.pc;   end
      else if (s.ecall)  begin m_mcause = 32'd11; m_mtval = 32'h0;  end
      else               begin m_mcause = 32'h8000_000B; m_mtval = 32'h0; end
      m_mpie = m_mie; m_mie = 1'b0; m_vec = 1'b1;
    end else if (s.mret) begin
      m_mie = m_mpie; m_mpie = 1'b1;
    end else if (s.csrwen) begin
      case (s.addr)
        12'h300: begin m_mie = s.wdata[3]; m_mpie = s.wdata[7]; end
        12'h304: m_meie = IRQ_EN && s.wdata[11];
        12'h305: m_mtvec = s.wdata & 32'hFFFF_FFFC;
        12'h341: m_mepc = s.wdata & 32'hFFFF_FFFC;
        12'h342: m_mcause = s.wdata;
        12'h343: m_mtval = s.wdata;
        default: ;
      endcase
    end
    #1;
  endtask

  initial begin
    stim_t s;
    logic [11:0] addrs [9];
    addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7C0, 12'h000};
    model_reset();

    // Reset and reset-value reads
    s = idle(32'h0); s.rst = 1'b1;
    cycle(s); cycle(s);
    cycle(rd(12'h305)); check("rst_mtvec", obs_rdata, 32'h0000_0100);
    check("rst_redirectpc", obs_rpc, 32'h0);
    cycle(rd(12'h342)); check("rst_mcause", obs_rdata, 32'h0);
    cycle(rd(12'h7C0)); check("rst_unmapped", obs_rdata, 32'h0);

    // Illegal instruction trap
    s = idle(32'h40); s.illegal = 1'b1; s.inst = 32'hFFFF_FFFF;
    cycle(s); check("ill_stall", 32'(obs_stall), 32'h1);
    cycle(idle(32'h44)); check("ill_redir", 32'(obs_redir), 32'h1);
    check("ill_vector", obs_rpc, 32'h100);
    cycle(rd(12'h341)); check("ill_mepc", obs_rdata, 32'h40);
    cycle(rd(12'h342)); check("ill_mcause", obs_rdata, 32'h2);
    cycle(rd(12'h343)); check("ill_mtval", obs_rdata, 32'hFFFF_FFFF);

    // ecall then mret
    cycle(wr(12'h300, 32'h8));
    s = idle(32'h80); s.ecall = 1'b1;
    cycle(s); check("ecall_stall", 32'(obs_stall), 32'h1);
    cycle(idle(32'h84));
    cycle(rd(12'h300)); check("ecall_mstatus", obs_rdata, 32'h80);
    cycle(rd(12'h342)); check("ecall_mcause", obs_rdata, 32'd11);
    s = rd(12'h300); s.mret = 1'b1;
    cycle(s); check("mret_redir", 32'(obs_redir), 32'h1);
    check("mret_pc", obs_rpc, 32'h80);
    check("mret_nostall", 32'(obs_stall), 32'h0);
    cycle(rd(12'h300)); check("mret_mstatus", obs_rdata, 32'h88);

    // ecall with simultaneous mtvec write: write dropped
    s = wr(12'h305, 32'h0000_0400); s.ecall = 1'b1; s.pc = 32'h90;
    cycle(s); check("ecw_stall", 32'(obs_stall), 32'h1);
    cycle(idle(32'h94)); check("ecw_vector", obs_rpc, 32'h100);
    cycle(rd(12'h305)); check("ecw_mtvec", obs_rdata, 32'h100);

    // External interrupt
    cycle(wr(12'h300, 32'h8));
    cycle(wr(12'h304, 32'h800));
    s = idle(32'h200); s.extirq = 1'b1;
    cycle(s); check("irq_stall", 32'(obs_stall), 32'(IRQ_EN));
    s.pc = 32'h204;
    cycle(s);
    cycle(rd(12'h342)); check("irq_mcause", obs_rdata, IRQ_EN ? 32'h8000_000B : 32'd11);
    cycle(rd(12'h341)); check("irq_mepc", obs_rdata, IRQ_EN ? 32'h200 : 32'h90);

    // Reset while in VECTOR
    s = idle(32'h44); s.ebreak = 1'b1;
    cycle(s);
    s = idle(32'h48); s.rst = 1'b1;
    cycle(s);
    cycle(rd(12'h300)); check("vrst_redir", 32'(obs_redir), 32'h0);
    check("vrst_mstatus", obs_rdata, 32'h0);
    cycle(rd(12'h305)); check("vrst_mtvec", obs_rdata, 32'h100);
    cycle(rd(12'h341)); check("vrst_mepc", obs_rdata, 32'h0);
    cycle(rd(12'h343)); check("vrst_mtval", obs_rdata, 32'h0);

    // Random stimulus
    for (int i = 0; i < 400; i++) begin
      s.rst     = ($urandom_range(59) == 0);
      s.pc      = $urandom;
      s.inst    = $urandom;
      s.illegal = ($urandom_range(15) == 0);
      s.ebreak  = ($urandom_range(15) == 0);
      s.ecall   = ($urandom_range(11) == 0);
      s.mret    = ($urandom_range(7) == 0);
      s.csrwen  = $urandom_range(1);
      s.addr    = addrs[$urandom_range(8)];
      s.wdata   = ($urandom_range(3) == 0) ? 32'h0000_0888 : $urandom;
      s.extirq  = ($urandom_range(2) == 0);
      cycle(s);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
